// File: rtl/sysid_pkg.sv
// Shared constants for the system-ID / build-info register block:
// bus widths and the word offsets of every mapped register.
package sysid_pkg;

    localparam int ADDR_W   = 4;
    localparam int DATA_W   = 32;
    localparam int UPTIME_W = 64;

    localparam logic [ADDR_W-1:0] SYSID_OFF_ID        = 4'd0;
    localparam logic [ADDR_W-1:0] SYSID_OFF_TIMESTAMP = 4'd1;
    localparam logic [ADDR_W-1:0] SYSID_OFF_VERSION   = 4'd2;
    localparam logic [ADDR_W-1:0] SYSID_OFF_CAPS      = 4'd3;
    localparam logic [ADDR_W-1:0] SYSID_OFF_SCRATCH   = 4'd4;
    localparam logic [ADDR_W-1:0] SYSID_OFF_UPTIME_LO = 4'd5;
    localparam logic [ADDR_W-1:0] SYSID_OFF_UPTIME_HI = 4'd6;
    localparam logic [ADDR_W-1:0] SYSID_OFF_CH_SEL    = 4'd7;
    localparam logic [ADDR_W-1:0] SYSID_OFF_CH_INFO   = 4'd8;

endpackage

// File: rtl/sysid_info_regs_if.sv
// Avalon-MM slave bundle for the system-ID register block: one-beat
// read/write strobes, fixed-latency read response.
interface sysid_info_regs_if;
    import sysid_pkg::*;

    logic [ADDR_W-1:0] address;
    logic              read;
    logic              write;
    logic [DATA_W-1:0] writedata;
    logic [DATA_W-1:0] readdata;
    logic              readdatavalid;

    modport master (
        output address, read, write, writedata,
        input  readdata, readdatavalid
    );

    modport slave (
        input  address, read, write, writedata,
        output readdata, readdatavalid
    );

endinterface

// File: rtl/sysid_uptime_counter.sv
// Free-running 64-bit uptime counter with a snapshot of the upper word,
// so software can read LO then HI and get a coherent 64-bit value.
module sysid_uptime_counter
    import sysid_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        snap,
    output logic [31:0] lo,
    output logic [31:0] hi_snap
);

    logic [UPTIME_W-1:0] count;

    // The snapshot takes the pre-increment upper word, matching the LO value returned on the same edge.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count   <= '0;
            hi_snap <= '0;
        end else begin
            count <= count + UPTIME_W'(1);
            if (snap) begin
                hi_snap <= count[UPTIME_W-1:32];
            end
        end
    end

    assign lo = count[31:0];

endmodule

// File: rtl/sysid_info_regs.sv
// System-ID / build-info register block: 16-word Avalon-MM map with
// RO build constants, scratch, coherent uptime and a per-channel info table.
module sysid_info_regs
    import sysid_pkg::*;
#(
    parameter logic [31:0]         SYSTEM_ID = 32'h0000_0001,
    parameter logic [31:0]         TIMESTAMP = 32'h0000_0000,
    parameter logic [7:0]          VER_MAJOR = 8'd2,
    parameter logic [7:0]          VER_MINOR = 8'd0,
    parameter int                  NUM_CH    = 4,
    parameter logic [NUM_CH*32-1:0] CH_INFO  = '0
)
(
    input  logic              clock,
    input  logic              reset,
    sysid_info_regs_if.slave  bus
);

    localparam logic [4:0] NUM_CH_FIELD = 5'(NUM_CH);

    logic [DATA_W-1:0] scratch;
    logic [3:0]        ch_sel;
    logic [DATA_W-1:0] read_word;
    logic [31:0]       uptime_lo;
    logic [31:0]       uptime_hi_snap;
    logic              uptime_snap;
    logic [DATA_W-1:0] ch_table [16];

    assign uptime_snap = bus.read && (bus.address == SYSID_OFF_UPTIME_LO);

    sysid_uptime_counter u_uptime (
        .clock   (clock),
        .reset   (reset),
        .snap    (uptime_snap),
        .lo      (uptime_lo),
        .hi_snap (uptime_hi_snap)
    );

    // Selectors past the last populated channel read as zero.
    for (genvar i = 0; i < 16; i++) begin : g_ch
        if (i < NUM_CH) begin : g_used
            assign ch_table[i] = CH_INFO[32*i +: 32];
        end else begin : g_unused
            assign ch_table[i] = '0;
        end
    end

    always_comb begin
        read_word = '0;
        case (bus.address)
            SYSID_OFF_ID:        read_word = SYSTEM_ID;
            SYSID_OFF_TIMESTAMP: read_word = TIMESTAMP;
            SYSID_OFF_VERSION:   read_word = {16'h0, VER_MAJOR, VER_MINOR};
            SYSID_OFF_CAPS:      read_word = {27'h0, NUM_CH_FIELD};
            SYSID_OFF_SCRATCH:   read_word = scratch;
            SYSID_OFF_UPTIME_LO: read_word = uptime_lo;
            SYSID_OFF_UPTIME_HI: read_word = uptime_hi_snap;
            SYSID_OFF_CH_SEL:    read_word = {28'h0, ch_sel};
            SYSID_OFF_CH_INFO:   read_word = ch_table[ch_sel];
            default:             read_word = '0;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            scratch <= '0;
            ch_sel  <= '0;
        end else if (bus.write) begin
            if (bus.address == SYSID_OFF_SCRATCH) begin
                scratch <= bus.writedata;
            end
            if (bus.address == SYSID_OFF_CH_SEL) begin
                ch_sel <= bus.writedata[3:0];
            end
        end
    end

    // The mux sees pre-write register values, so a same-cycle read+write returns the old data.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            bus.readdata      <= '0;
            bus.readdatavalid <= 1'b0;
        end else begin
            bus.readdatavalid <= bus.read;
            if (bus.read) begin
                bus.readdata <= read_word;
            end
        end
    end

endmodule

// File: tb/tb_sysid_info_regs.sv
// Self-checking bench for sysid_info_regs: directed vector table, hand-written
// corner sequences and randomized traffic against a behavioural model.
module tb_sysid_info_regs;

    localparam logic [31:0] TB_SYSTEM_ID = 32'h1234_5678;
    localparam logic [31:0] TB_TIMESTAMP = 32'h6500_0000;

    logic clock = 1'b0;
    logic reset = 1'b1;

    int tests_run    = 0;
    int tests_failed = 0;

    sysid_info_regs_if bus ();

    sysid_info_regs #(
        .SYSTEM_ID (TB_SYSTEM_ID),
        .TIMESTAMP (TB_TIMESTAMP),
        .VER_MAJOR (8'd2),
        .VER_MINOR (8'd0),
        .NUM_CH    (4),
        .CH_INFO   ({32'hD, 32'hC, 32'hB, 32'hA})
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    logic [63:0] cycle_no = '0;
    always @(posedge clock) cycle_no <= cycle_no + 64'd1;

    // Reference model: uptime is "value at a known cycle plus cycles elapsed since".
    logic [63:0] base_value;
    logic [63:0] base_cycle;
    logic [31:0] m_scratch;
    logic [3:0]  m_ch_sel;
    logic [31:0] m_hi;
    logic [31:0] last_data;
    logic [31:0] ch_ref [4] = '{32'hA, 32'hB, 32'hC, 32'hD};

    typedef struct {
        string       name;
        logic        rd;
        logic        wr;
        logic [3:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [63:0] model_uptime();
        return base_value + (cycle_no - base_cycle);
    endfunction

    function automatic logic [31:0] model_read(input logic [3:0] a);
        logic [63:0] up;
        up = model_uptime();
        case (a)
            4'd0:    return TB_SYSTEM_ID;
            4'd1:    return TB_TIMESTAMP;
            4'd2:    return 32'h0000_0200;
            4'd3:    return 32'd4;
            4'd4:    return m_scratch;
            4'd5:    return up[31:0];
            4'd6:    return m_hi;
            4'd7:    return {28'h0, m_ch_sel};
            4'd8:    return (m_ch_sel < 4) ? ch_ref[m_ch_sel] : 32'h0;
            default: return 32'h0;
        endcase
    endfunction

    task automatic model_reset();
        m_scratch  = '0;
        m_ch_sel   = '0;
        m_hi       = '0;
        last_data  = '0;
        base_value = '0;
        base_cycle = cycle_no;
    endtask

    // Called at a negedge: drives one bus cycle, updates the model, returns after the edge.
    task automatic applyStimulus(input logic r, input logic w, input logic [3:0] a,
                                 input logic [31:0] d, output logic [31:0] exp);
        logic [63:0] up;
        up  = model_uptime();
        exp = model_read(a);
        if (r && a == 4'd5) m_hi = up[63:32];
        if (w && a == 4'd4) m_scratch = d;
        if (w && a == 4'd7) m_ch_sel = d[3:0];
        bus.read      = r;
        bus.write     = w;
        bus.address   = a;
        bus.writedata = d;
        @(negedge clock);
        bus.read  = 1'b0;
        bus.write = 1'b0;
    endtask

    task automatic checkOutput(input string name, input logic exp_valid, input logic [31:0] exp_data);
        tests_run++;
        if (bus.readdatavalid !== exp_valid) begin
            tests_failed++;
            $display("[TB] FAIL %s readdatavalid actual %0b required %0b", name, bus.readdatavalid, exp_valid);
        end
        tests_run++;
        if (bus.readdata !== exp_data) begin
            tests_failed++;
            $display("[TB] FAIL %s readdata actual %08h required %08h", name, bus.readdata, exp_data);
        end
        if (exp_valid) last_data = exp_data;
    endtask

    task automatic opAndCheck(input string name, input logic r, input logic w,
                              input logic [3:0] a, input logic [31:0] d);
        logic [31:0] exp;
        applyStimulus(r, w, a, d, exp);
        checkOutput(name, r, r ? exp : last_data);
    endtask

    task automatic addVec(input string n, input logic r, input logic w, input logic [3:0] a,
                          input logic [31:0] d, input logic [31:0] e);
        vec_t v;
        v.name = n; v.rd = r; v.wr = w; v.addr = a; v.wdata = d; v.exp = e;
        vecs.push_back(v);
    endtask

    task automatic doReset();
        reset = 1'b1;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        model_reset();
    endtask

    initial begin
        logic [31:0] exp;

        bus.read      = 1'b0;
        bus.write     = 1'b0;
        bus.address   = '0;
        bus.writedata = '0;
        model_reset();

        addVec("id",             1, 0, 4'd0,  32'h0,         32'h1234_5678);
        addVec("version",        1, 0, 4'd2,  32'h0,         32'h0000_0200);
        addVec("caps",           1, 0, 4'd3,  32'h0,         32'h0000_0004);
        addVec("timestamp",      1, 0, 4'd1,  32'h0,         32'h6500_0000);
        addVec("scratch_wr",     0, 1, 4'd4,  32'hA5A5_5A5A, 32'h0);
        addVec("scratch_rd",     1, 0, 4'd4,  32'h0,         32'hA5A5_5A5A);
        addVec("id_wr",          0, 1, 4'd0,  32'hFFFF_FFFF, 32'h0);
        addVec("id_after_wr",    1, 0, 4'd0,  32'h0,         32'h1234_5678);
        addVec("unmapped_12",    1, 0, 4'd12, 32'h0,         32'h0);
        addVec("chsel_2",        0, 1, 4'd7,  32'h2,         32'h0);
        addVec("chinfo_2",       1, 0, 4'd8,  32'h0,         32'h0000_000C);
        addVec("chsel_5",        0, 1, 4'd7,  32'h5,         32'h0);
        addVec("chinfo_5",       1, 0, 4'd8,  32'h0,         32'h0);
        addVec("chsel_trunc_wr", 0, 1, 4'd7,  32'hFFFF_FFF1, 32'h0);
        addVec("chsel_trunc_rd", 1, 0, 4'd7,  32'h0,         32'h0000_0001);
        addVec("chinfo_1",       1, 0, 4'd8,  32'h0,         32'h0000_000B);
        addVec("unmapped_wr",    0, 1, 4'd13, 32'hDEAD_BEEF, 32'h0);
        addVec("unmapped_13",    1, 0, 4'd13, 32'h0,         32'h0);

        @(negedge clock);
        doReset();
        checkOutput("reset_state", 1'b0, 32'h0);
        opAndCheck("scratch_reset", 1, 0, 4'd4, 32'h0);
        opAndCheck("chsel_reset",   1, 0, 4'd7, 32'h0);
        opAndCheck("uptime_hi_reset", 1, 0, 4'd6, 32'h0);

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata, exp);
            checkOutput(vecs[i].name, vecs[i].rd, vecs[i].rd ? vecs[i].exp : last_data);
        end

        // Coherent uptime across a low-word rollover.
        force dut.u_uptime.count = 64'h0000_0005_FFFF_FFFA;
        #1;
        release dut.u_uptime.count;
        base_value = 64'h0000_0005_FFFF_FFFA;
        base_cycle = cycle_no;
        applyStimulus(1, 0, 4'd5, 32'h0, exp);
        checkOutput("uptime_lo", 1'b1, 32'hFFFF_FFFA);
        repeat (9) opAndCheck("uptime_idle", 0, 0, 4'd0, 32'h0);
        applyStimulus(1, 0, 4'd6, 32'h0, exp);
        checkOutput("uptime_hi_snap", 1'b1, 32'h0000_0005);
        opAndCheck("uptime_lo_wrapped", 1, 0, 4'd5, 32'h0);
        opAndCheck("uptime_hi_new",     1, 0, 4'd6, 32'h0);

        // Read and write to the same register in one cycle.
        opAndCheck("scratch_set1", 0, 1, 4'd4, 32'h1);
        applyStimulus(1, 1, 4'd4, 32'h2, exp);
        checkOutput("rw_same_cycle", 1'b1, 32'h1);
        applyStimulus(1, 0, 4'd4, 32'h0, exp);
        checkOutput("rw_after", 1'b1, 32'h2);
        opAndCheck("b2b_0", 1, 0, 4'd0, 32'h0);
        opAndCheck("b2b_1", 1, 0, 4'd1, 32'h0);
        opAndCheck("b2b_2", 1, 0, 4'd2, 32'h0);
        opAndCheck("b2b_3", 1, 0, 4'd3, 32'h0);
        opAndCheck("b2b_4", 1, 0, 4'd4, 32'h0);
        opAndCheck("b2b_5", 1, 0, 4'd7, 32'h0);
        opAndCheck("b2b_6", 1, 0, 4'd8, 32'h0);
        opAndCheck("b2b_7", 1, 0, 4'd5, 32'h0);
        opAndCheck("b2b_idle", 0, 0, 4'd0, 32'h0);

        // Reset arriving while a read is outstanding must swallow the response.
        opAndCheck("scratch_set77", 0, 1, 4'd4, 32'h77);
        bus.read    = 1'b1;
        bus.address = 4'd4;
        #3 reset = 1'b1;
        @(negedge clock);
        bus.read = 1'b0;
        checkOutput("reset_mid_read", 1'b0, 32'h0);
        @(negedge clock);
        checkOutput("reset_held", 1'b0, 32'h0);
        reset = 1'b0;
        model_reset();
        opAndCheck("after_release", 0, 0, 4'd0, 32'h0);
        opAndCheck("scratch_after_reset", 1, 0, 4'd4, 32'h0);

        for (int n = 0; n < 400; n++) begin
            logic r, w;
            logic [3:0] a;
            r = 1'($urandom_range(0, 1));
            w = ($urandom_range(0, 2) == 0);
            a = 4'($urandom_range(0, 15));
            opAndCheck("random", r, w, a, $urandom);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
